// File: rtl/result_arbiter_pkg.sv
// Shared types and default widths for the result arbiter.
// Holds the FSM state enum and the packed result word layout.
package result_arbiter_pkg;

  localparam int CORES_D   = 4;
  localparam int QDEPTH_D  = 4;
  localparam int X_W_D     = 9;
  localparam int Y_W_D     = 9;
  localparam int SCALE_W_D = 5;
  localparam int CNT_W_D   = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_t;

  // Result word at default widths: {hit, scale, y, x}.
  typedef struct packed {
    logic                 hit;
    logic [SCALE_W_D-1:0] scale;
    logic [Y_W_D-1:0]     y;
    logic [X_W_D-1:0]     x;
  } res_word_t;

endpackage

// File: rtl/result_arbiter_if.sv
// Per-core result inputs and result-queue output bus.
// master: arbiter side; slave: cores plus result queue.
interface result_arbiter_if
  import result_arbiter_pkg::*;
#(
  parameter int CORES   = CORES_D,
  parameter int X_W     = X_W_D,
  parameter int Y_W     = Y_W_D,
  parameter int SCALE_W = SCALE_W_D
);
  localparam int DW = 1 + SCALE_W + Y_W + X_W;

  logic [CORES-1:0]     pr_valid;
  logic [CORES-1:0]     pr_hit;
  logic [CORES*X_W-1:0] pr_x;
  logic [CORES*Y_W-1:0] pr_y;
  logic [CORES-1:0]     pr_last;
  logic [CORES-1:0]     pr_ready;
  logic                 rq_valid;
  logic [DW-1:0]        rq_data;
  logic                 rq_ready;

  modport master (
    input  pr_valid, pr_hit, pr_x, pr_y,
    input  pr_last, rq_ready,
    output pr_ready, rq_valid, rq_data
  );

  modport slave (
    output pr_valid, pr_hit, pr_x, pr_y,
    output pr_last, rq_ready,
    input  pr_ready, rq_valid, rq_data
  );

endinterface

// File: rtl/result_arbiter_fifo.sv
// result_fifo: per-core FIFO, synchronous flush,
// registered full/empty; ports clk/reset/flush/wr/rd/data.
module result_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt, cnt_n;
  logic          wr_en, rd_en;

  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;
  assign cnt_n = cnt + (AW+1)'(wr_en)
               - (AW+1)'(rd_en);
  assign rdata = mem[rp];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      cnt   <= cnt_n;
      full  <= cnt_n == (AW+1)'(DEPTH);
      empty <= cnt_n == '0;
    end
  end

endmodule

// File: rtl/result_arbiter.sv
// Collects per-core results into FIFOs, arbitrates them
// round-robin into one result queue; pass FSM + hit count.
module result_arbiter
  import result_arbiter_pkg::*;
#(
  parameter int CORES   = CORES_D,
  parameter int QDEPTH  = QDEPTH_D,
  parameter int X_W     = X_W_D,
  parameter int Y_W     = Y_W_D,
  parameter int SCALE_W = SCALE_W_D,
  parameter int CNT_W   = CNT_W_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SCALE_W-1:0] scale,
  input  logic               mode_all,
  result_arbiter_if.master   bus,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   hit_count
);
  localparam int FW = 1 + Y_W + X_W;
  localparam int DW = 1 + SCALE_W + Y_W + X_W;
  localparam int CW = (CORES > 1) ? $clog2(CORES) : 1;

  state_t             state, state_n;
  logic [CORES-1:0]   last_seen;
  logic [CORES-1:0]   full, empty;
  logic [CORES-1:0]   acc, enq, deq;
  logic [FW-1:0]      fifo_q [CORES];
  logic [SCALE_W-1:0] scale_q;
  logic               mode_q;
  logic [CW-1:0]      rr, gidx;
  logic               gvalid, load, clr;
  logic [FW-1:0]      gword;
  logic               rq_valid_q;
  logic [DW-1:0]      rq_data_q;
  logic [CNT_W+5:0]   hsum;

  assign clr = (state == S_IDLE) && start;

  assign bus.pr_ready = {CORES{state == S_COLLECT}}
                      & ~full & ~last_seen;
  assign acc = bus.pr_valid & bus.pr_ready;
  // Rejects are consumed but only forwarded in mode_all.
  assign enq = acc & (bus.pr_hit | {CORES{mode_q}});

  for (genvar i = 0; i < CORES; i++) begin : g_fifo
    result_fifo #(
      .W     (FW),
      .DEPTH (QDEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (clr),
      .wr    (enq[i]),
      .wdata ({bus.pr_hit[i],
               bus.pr_y[i*Y_W +: Y_W],
               bus.pr_x[i*X_W +: X_W]}),
      .rd    (deq[i]),
      .rdata (fifo_q[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // rr holds the highest-priority core for the next grant.
  always_comb begin
    int j;
    gvalid = 1'b0;
    gidx   = '0;
    j      = 0;
    for (int k = 0; k < CORES; k++) begin
      j = (int'(rr) + k) % CORES;
      if (!gvalid && !empty[j]) begin
        gvalid = 1'b1;
        gidx   = CW'(j);
      end
    end
  end

  assign load  = !rq_valid_q || bus.rq_ready;
  assign gword = fifo_q[gidx];

  always_comb begin
    deq = '0;
    if (load && gvalid) deq[gidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rq_valid_q <= 1'b0;
      rq_data_q  <= '0;
      rr         <= '0;
    end else if (load) begin
      rq_valid_q <= gvalid;
      if (gvalid) begin
        rq_data_q <= {gword[FW-1], scale_q,
                      gword[FW-2:0]};
        rr <= (gidx == CW'(CORES-1)) ? '0
            : gidx + CW'(1);
      end
    end
  end

  assign bus.rq_valid = rq_valid_q;
  assign bus.rq_data  = rq_data_q;

  assign hsum = (CNT_W+6)'(hit_count)
              + (CNT_W+6)'($countones(acc & bus.pr_hit));

  always_ff @(posedge clk) begin
    if (reset) begin
      last_seen <= '0;
      hit_count <= '0;
      scale_q   <= '0;
      mode_q    <= 1'b0;
    end else if (clr) begin
      last_seen <= '0;
      hit_count <= '0;
      scale_q   <= scale;
      mode_q    <= mode_all;
    end else begin
      last_seen <= last_seen | (acc & bus.pr_last);
      hit_count <= (|hsum[CNT_W+5:CNT_W]) ? '1
                 : hsum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (start) state_n = S_COLLECT;
      S_COLLECT: if (&last_seen) state_n = S_DRAIN;
      S_DRAIN:   if (&empty && !rq_valid_q)
                   state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy = state != S_IDLE;
    done = state == S_DONE;
  end

endmodule

// File: tb/tb_result_arbiter.sv
// Scoreboard bench for result_arbiter: random and directed
// passes, per-core expected queues, monitor at negedge.
module tb_result_arbiter;
  import result_arbiter_pkg::*;

  localparam int CORES   = 4;
  localparam int QDEPTH  = 4;
  localparam int X_W     = 9;
  localparam int Y_W     = 9;
  localparam int SCALE_W = 5;
  localparam int CNT_W   = 4;
  localparam int DW      = 1 + SCALE_W + Y_W + X_W;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               mode_all;
  logic [SCALE_W-1:0] scale;
  logic               busy, done;
  logic [CNT_W-1:0]   hit_count;

  result_arbiter_if #(
    .CORES(CORES), .X_W(X_W),
    .Y_W(Y_W), .SCALE_W(SCALE_W)
  ) bus ();

  result_arbiter #(
    .CORES(CORES), .QDEPTH(QDEPTH), .X_W(X_W),
    .Y_W(Y_W), .SCALE_W(SCALE_W), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .scale     (scale),
    .mode_all  (mode_all),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           hit;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
    logic           last;
  } beat_t;

  beat_t              src_q [CORES][$];
  logic [DW-1:0]      exp_q [CORES][$];
  int                 edge_q [CORES][$];
  logic [DW-1:0]      out_log [$];
  logic [CORES-1:0]   acc_flag = '0;
  logic [CORES-1:0]   m_last = '0;
  int                 acc_cnt [CORES];
  int                 total = 0;
  int                 bad = 0;
  int                 cyc = 0;
  int                 done_cnt = 0;
  int                 m_hits = 0;
  logic               m_busy = 1'b0;
  logic               m_mode = 1'b0;
  logic [SCALE_W-1:0] m_scale = '0;
  int                 rq_mode = 0;
  bit                 gaps = 1'b0;
  logic               stall_prev = 1'b0;
  logic [DW-1:0]      data_prev = '0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    res_word_t w;
    int c;
    bit all_empty;
    logic [X_W-1:0] bx;
    logic [Y_W-1:0] by;
    if (reset) begin
      for (int i = 0; i < CORES; i++) begin
        exp_q[i].delete();
        edge_q[i].delete();
      end
      acc_flag   = '0;
      m_last     = '0;
      m_hits     = 0;
      m_busy     = 1'b0;
      stall_prev = 1'b0;
    end else begin
      chk("hit_count", hit_count, m_hits);
      if (done) begin
        done_cnt++;
        all_empty = 1'b1;
        for (int i = 0; i < CORES; i++)
          if (exp_q[i].size() != 0) all_empty = 1'b0;
        chk("done_ok", {m_busy, all_empty, &m_last},
            3'b111);
        chk("rq_valid_at_done", bus.rq_valid, 0);
        m_busy = 1'b0;
      end
      if (stall_prev) begin
        chk("hold_valid", bus.rq_valid, 1);
        chk("hold_data", bus.rq_data, data_prev);
      end
      stall_prev = bus.rq_valid && !bus.rq_ready;
      data_prev  = bus.rq_data;
      if (bus.rq_valid && bus.rq_ready) begin
        w = bus.rq_data;
        c = int'(w.x[1:0]);
        out_log.push_back(bus.rq_data);
        if (exp_q[c].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h",
                   bus.rq_data);
        end else begin
          chk("rq_data", bus.rq_data,
              exp_q[c].pop_front());
          chk("latency", cyc > edge_q[c].pop_front(), 1);
        end
      end
      if (start && !m_busy) begin
        m_busy  = 1'b1;
        m_hits  = 0;
        m_scale = scale;
        m_mode  = mode_all;
        m_last  = '0;
      end
      for (int i = 0; i < CORES; i++) begin
        if (bus.pr_valid[i] && bus.pr_ready[i]) begin
          acc_flag[i] = 1'b1;
          acc_cnt[i]++;
          bx = bus.pr_x[i*X_W +: X_W];
          by = bus.pr_y[i*Y_W +: Y_W];
          if (bus.pr_hit[i])
            m_hits = (m_hits >= CMAX) ? CMAX
                   : m_hits + 1;
          if (bus.pr_hit[i] || m_mode) begin
            exp_q[i].push_back({bus.pr_hit[i], m_scale,
                                by, bx});
            edge_q[i].push_back(cyc + 1);
          end
          if (bus.pr_last[i]) m_last[i] = 1'b1;
        end
      end
    end
  end

  // Source driver: presents each core's queue head.
  initial begin
    beat_t b;
    bit v;
    bus.pr_valid = '0;
    bus.pr_hit   = '0;
    bus.pr_x     = '0;
    bus.pr_y     = '0;
    bus.pr_last  = '0;
    bus.rq_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < CORES; i++) begin
        if (acc_flag[i]) begin
          if (src_q[i].size() != 0)
            void'(src_q[i].pop_front());
          acc_flag[i] = 1'b0;
        end
        v = (src_q[i].size() > 0) &&
            (!gaps || $urandom_range(3) != 0);
        bus.pr_valid[i] = v;
        if (v) begin
          b = src_q[i][0];
          bus.pr_hit[i]             = b.hit;
          bus.pr_x[i*X_W +: X_W]    = b.x;
          bus.pr_y[i*Y_W +: Y_W]    = b.y;
          bus.pr_last[i]            = b.last;
        end
      end
      if (rq_mode == 0)      bus.rq_ready = 1'b1;
      else if (rq_mode == 1) bus.rq_ready = 1'b0;
      else bus.rq_ready = $urandom_range(3) != 0;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_start(logic m, logic [SCALE_W-1:0] s);
    start    = 1'b1;
    mode_all = m;
    scale    = s;
    tick(1);
    start    = 1'b0;
  endtask

  // x carries the core id in its low two bits.
  task automatic push(int c, logic hit, int y,
                      int xh, logic last);
    beat_t b;
    b.hit  = hit;
    b.y    = Y_W'(y);
    b.x    = {7'(xh), 2'(c)};
    b.last = last;
    src_q[c].push_back(b);
  endtask

  task automatic wait_done(int lim, string name);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < lim) begin
      tick(1);
      n++;
    end
    tick(3);
    chk(name, done_cnt - d0, 1);
  endtask

  initial begin
    int n;
    int d0;
    logic [DW-1:0] wd;
    reset    = 1'b1;
    start    = 1'b0;
    mode_all = 1'b0;
    scale    = '0;
    for (int i = 0; i < CORES; i++) acc_cnt[i] = 0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rq_valid", bus.rq_valid, 0);
    chk("rst_rq_data", bus.rq_data, 0);
    chk("rst_pr_ready", bus.pr_ready, 0);
    chk("rst_hit_count", hit_count, 0);
    reset = 1'b0;
    tick(2);

    // One result per core, in-order grants.
    rq_mode = 0;
    do_start(1'b1, 5'd2);
    chk("busy_after_start", busy, 1);
    out_log.delete();
    push(0, 1'b1, 10, 3, 1'b1);
    push(1, 1'b0, 11, 4, 1'b1);
    push(2, 1'b1, 12, 5, 1'b1);
    push(3, 1'b1, 13, 6, 1'b1);
    wait_done(200, "done_basic");
    chk("basic_cnt", out_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < out_log.size()) begin
        wd = out_log[k];
        chk("basic_order", wd[1:0], k);
      end
    chk("basic_hits", hit_count, 3);
    chk("busy_idle", busy, 0);

    // Hits-only: three rejects then one hit.
    do_start(1'b0, 5'd3);
    out_log.delete();
    push(1, 1'b0, 1, 9, 1'b0);
    push(1, 1'b0, 2, 9, 1'b0);
    push(1, 1'b0, 3, 9, 1'b0);
    push(1, 1'b1, 7, 1, 1'b1);
    push(0, 1'b0, 0, 2, 1'b1);
    push(2, 1'b0, 0, 2, 1'b1);
    push(3, 1'b0, 0, 2, 1'b1);
    wait_done(200, "done_hits_only");
    chk("hits_only_cnt", out_log.size(), 1);
    if (out_log.size() > 0)
      chk("hits_only_word", out_log[0],
          {1'b1, 5'd3, 9'd7, 9'd5});

    // Back-pressure: core0 fills FIFO plus output reg.
    do_start(1'b1, 5'd7);
    rq_mode = 1;
    out_log.delete();
    for (int i = 0; i < CORES; i++) acc_cnt[i] = 0;
    for (int k = 0; k < 6; k++)
      push(0, 1'(k % 2), k, k + 20, k == 5);
    tick(20);
    chk("stall_accepts", acc_cnt[0], QDEPTH + 1);
    chk("stall_ready0", bus.pr_ready[0], 0);
    chk("stall_valid", bus.rq_valid, 1);
    rq_mode = 0;
    for (int i = 1; i < CORES; i++)
      push(i, 1'b1, 40, 40 + i, 1'b1);
    wait_done(300, "done_stall");
    chk("stall_out_cnt", out_log.size(), 9);

    // All cores streaming: grants rotate.
    do_start(1'b1, 5'd9);
    out_log.delete();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < CORES; i++)
        push(i, 1'b0, k, 50 + k, k == 3);
    wait_done(300, "done_rotate");
    chk("rotate_cnt", out_log.size(), 16);
    for (int k = 0; k + 1 < out_log.size(); k++) begin
      wd = out_log[k];
      n  = (int'(wd[1:0]) + 1) % CORES;
      wd = out_log[k + 1];
      chk("rotate_next", wd[1:0], n);
    end

    // Ignored restart, hit counter saturation.
    do_start(1'b1, 5'd4);
    out_log.delete();
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < CORES; i++)
        push(i, 1'b1, $urandom_range(511),
             $urandom_range(127), k == 4);
    tick(2);
    do_start(1'b0, 5'd11);
    chk("restart_busy", busy, 1);
    wait_done(400, "done_sat");
    chk("sat_hit_count", hit_count, CMAX);
    chk("sat_out_cnt", out_log.size(), 20);

    // Reset during drain with queued words.
    rq_mode = 1;
    do_start(1'b0, 5'd6);
    push(0, 1'b1, 1, 60, 1'b0);
    push(0, 1'b1, 2, 61, 1'b0);
    push(0, 1'b1, 3, 62, 1'b1);
    for (int i = 1; i < CORES; i++)
      push(i, 1'b0, 0, 63, 1'b1);
    tick(12);
    chk("drain_busy", busy, 1);
    chk("drain_valid", bus.rq_valid, 1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_valid", bus.rq_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    reset   = 1'b0;
    rq_mode = 0;
    d0 = done_cnt;
    tick(10);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_idle_valid", bus.rq_valid, 0);

    // Randomised passes.
    gaps = 1'b1;
    rq_mode = 2;
    for (int p = 0; p < 8; p++) begin
      do_start(1'($urandom_range(1)),
               SCALE_W'($urandom_range(31)));
      for (int i = 0; i < CORES; i++) begin
        n = $urandom_range(6, 1);
        for (int k = 0; k < n; k++)
          push(i, 1'($urandom_range(1)),
               $urandom_range(511),
               $urandom_range(127), k == n - 1);
      end
      wait_done(2000, "done_random");
      tick(2);
    end
    gaps = 1'b0;
    rq_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_arbiter.md
RESULT_ARBITER -- requirements
Module: result_arbiter

Interface
REQ-001 SHALL have parameter CORES, default 4, number of processor result channels (1..16).
REQ-002 SHALL have parameter QDEPTH, default 4, entries per per-core FIFO (power of two, >=2).
REQ-003 SHALL have parameter X_W, default 9, window x-coordinate width.
REQ-004 SHALL have parameter Y_W, default 9, window y-coordinate width.
REQ-005 SHALL have parameter SCALE_W, default 5, scale-index width.
REQ-006 SHALL have parameter CNT_W, default 16, hit-counter width.
REQ-007 clk  input  1  sole clock; all logic on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 start  input  1  pulse; begins a scale pass.
REQ-010 scale  input  SCALE_W  scale tag, latched on accepted start.
REQ-011 mode_all  input  1  latched on start; 1 forwards all results, 0 forwards hits only.
REQ-012 pr_valid  input  CORES  per-core result valid.
REQ-013 pr_hit  input  CORES  per-core pass (1) / reject (0).
REQ-014 pr_x  input  CORES*X_W  per-core x, core i at bits [i*X_W +: X_W].
REQ-015 pr_y  input  CORES*Y_W  per-core y, same packing.
REQ-016 pr_last  input  CORES  marks core's final result of the pass.
REQ-017 pr_ready  output  CORES  per-core accept.
REQ-018 rq_valid  output  1  result word valid toward result queue.
REQ-019 rq_data  output  1+SCALE_W+Y_W+X_W  packed {hit, scale, y, x}.
REQ-020 rq_ready  input  1  result queue accepts word.
REQ-021 busy  output  1  high in any state but IDLE.
REQ-022 done  output  1  one-cycle pulse at pass completion.
REQ-023 hit_count  output  CNT_W  hits accepted this pass.

Function
REQ-024 FSM states IDLE, COLLECT, DRAIN, DONE; start accepted only in IDLE, ignored elsewhere.
REQ-025 IDLE->COLLECT on start; clears last_seen flags, FIFOs, hit_count; latches scale, mode_all.
REQ-026 pr_ready[i] = (COLLECT) & !fifo_full[i] & !last_seen[i]; transfer on pr_valid[i]&pr_ready[i].
REQ-027 Accepted beat with hit=0 while mode_all=0 is consumed but not enqueued; its pr_last still counts.
REQ-028 last_seen[i] sets on accepted beat with pr_last[i]=1; COLLECT->DRAIN the cycle after all CORES flags are set.
REQ-029 DRAIN->DONE when all FIFOs empty and rq_valid=0; DONE lasts one cycle with done=1, then IDLE.
REQ-030 Output register loads when empty or (rq_valid & rq_ready); source chosen round-robin among non-empty FIFOs, starting at core after last granted.
REQ-031 rq_valid/rq_data SHALL hold stable while rq_valid=1 and rq_ready=0.
REQ-032 Latency: result accepted at cycle t reaches rq_valid no earlier than t+2 (FIFO write, then output register).
REQ-033 Simultaneous FIFO write and read permitted at any non-full occupancy; full FIFO deasserts pr_ready only for that core.
REQ-034 hit_count increments per accepted hit regardless of mode_all, saturates at all-ones.
REQ-035 No result SHALL be dropped, duplicated or reordered within one core.

Reset
REQ-036 reset SHALL force IDLE, empty FIFOs, rq_valid=0, rq_data=0, pr_ready=0, busy=0, done=0, hit_count=0, RR pointer=0.
REQ-037 reset mid-pass SHALL discard all in-flight results; done SHALL NOT pulse.

Structure
REQ-038 Result-word struct and state enum SHALL live in the shared structs package; default widths in globalDefinitions.
REQ-039 One sub-module result_fifo (parametrised width/depth, registered full/empty) SHALL be instantiated per core via generate.

Verification
REQ-040 CORES=4, mode_all=1, one result per core each with pr_last, rq_ready=1 -> 4 words out in order core0..3, done pulses once, hit_count=popcount(hits).
REQ-041 mode_all=0, core1 sends 3 rejects then hit (x=5,y=7,last), scale=3 -> single word {1,3,7,5}, then done.
REQ-042 rq_ready=0 for 20 cycles, core0 sends 6 results -> pr_ready[0] falls after 4 (QDEPTH) accepts plus output reg; rq_data stable; all 6 emerge on release.
REQ-043 All cores continuously valid, rq_ready=1 -> grants rotate 0,1,2,3,0 with no core starved.
REQ-044 reset asserted during DRAIN with 3 queued words -> next cycle rq_valid=0, busy=0, no done pulse.
REQ-045 start while busy, and hit_count saturation with CNT_W=4 after 20 hits -> start ignored, hit_count=15.
